// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a circular FIFO of {instruction, address} pairs between fetch and decode.
// A decode stall keeps the head entry in place, and any flush source discards all queued wrong-path entries.
module if_id_queue #(
    parameter int                INST_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INST_W-1:0]        inst_i,
    input  logic [ADDR_W-1:0]        inst_addr_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     jump_flag_i,
    input  logic                     int_flag_i,
    input  logic                     halt_req_i,
    input  logic                     hold_i,
    output logic                     out_valid_o,
    output logic [INST_W-1:0]        inst_o,
    output logic [ADDR_W-1:0]        inst_addr_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // The pointers only wrap for free if the depth is a power of two.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("if_id_queue: DEPTH must be a power of 2 and >= 2");
    end

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic flush;
    logic push;
    logic pop;
    entry_t head;

    assign flush = jump_flag_i | int_flag_i | halt_req_i;

    // Ready looks only at occupancy, never at in_valid_i. A pop in the same
    // cycle does not make room.
    assign in_ready_o  = !rst && !halt_req_i && (count < FULL_CNT);
    assign out_valid_o = (count != '0) && !flush;

    assign push = in_valid_i && in_ready_o && !flush;
    assign pop  = out_valid_o && !hold_i;

    assign head        = mem[rd_ptr];
    assign inst_o      = out_valid_o ? head.inst : NOP_INST;
    assign inst_addr_o = out_valid_o ? head.addr : '0;
    assign count_o     = count;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset. Every read is masked by out_valid_o, so stale
    // contents are never visible, and dropping the reset lets this map onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{inst: inst_i, addr: inst_addr_i};
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue. A queue model is updated alongside the stimulus,
// and each cycle the DUT head, ready, valid and count are compared against it.
module tb_if_id_queue;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [INST_W-1:0] NOP = 32'h00000013;

    logic              clk;
    logic              rst;
    logic [INST_W-1:0] inst_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              jump_flag_i;
    logic              int_flag_i;
    logic              halt_req_i;
    logic              hold_i;
    logic              out_valid_o;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic [CNT_W-1:0]  count_o;

    typedef struct {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
    } ent_t;

    ent_t model_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    if_id_queue #(
        .INST_W  (INST_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .NOP_INST(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_i     (inst_i),
        .inst_addr_i(inst_addr_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .jump_flag_i(jump_flag_i),
        .int_flag_i (int_flag_i),
        .halt_req_i (halt_req_i),
        .hold_i     (hold_i),
        .out_valid_o(out_valid_o),
        .inst_o     (inst_o),
        .inst_addr_o(inst_addr_o),
        .count_o    (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bound on total run time: a stuck simulation is reported, then stopped.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
        $fatal(1, "watchdog expired");
    end

    // One clock cycle. Inputs are already set, starting 1 time unit after a rising edge.
    // At the falling edge the DUT is compared with the model, the model is updated, and
    // the task returns 1 unit after the next rising edge.
    task automatic tick();
        logic exp_flush, exp_ready, exp_valid;
        logic [INST_W-1:0] exp_inst;
        logic [ADDR_W-1:0] exp_addr;
        @(negedge clk);
        exp_flush = jump_flag_i | int_flag_i | halt_req_i;
        exp_ready = !halt_req_i && (model_q.size() < DEPTH);
        exp_valid = (model_q.size() != 0) && !exp_flush;
        exp_inst  = exp_valid ? model_q[0].inst : NOP;
        exp_addr  = exp_valid ? model_q[0].addr : '0;
        n_checks++;
        if (in_ready_o !== exp_ready) begin
            n_fail++;
            $display("FAIL sb_ready @%0t: got %b expected %b", $time, in_ready_o, exp_ready);
        end
        n_checks++;
        if (out_valid_o !== exp_valid) begin
            n_fail++;
            $display("FAIL sb_valid @%0t: got %b expected %b", $time, out_valid_o, exp_valid);
        end
        n_checks++;
        if (count_o !== CNT_W'(model_q.size())) begin
            n_fail++;
            $display("FAIL sb_count @%0t: got %0d expected %0d", $time, count_o, model_q.size());
        end
        n_checks++;
        if (inst_o !== exp_inst || inst_addr_o !== exp_addr) begin
            n_fail++;
            $display("FAIL sb_head @%0t: got %h@%h expected %h@%h", $time, inst_o, inst_addr_o,
                     exp_inst, exp_addr);
        end
        if (exp_flush) begin
            model_q.delete();
        end else begin
            if (exp_valid && !hold_i) void'(model_q.pop_front());
            if (in_valid_i && exp_ready) model_q.push_back('{inst: inst_i, addr: inst_addr_i});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid_i  = 1'b0;
        jump_flag_i = 1'b0;
        int_flag_i  = 1'b0;
        halt_req_i  = 1'b0;
        hold_i      = 1'b0;
        inst_i      = '0;
        inst_addr_i = '0;
    endtask

    task automatic drive_push(input logic [31:0] inst, input logic [31:0] addr);
        in_valid_i  = 1'b1;
        inst_i      = inst;
        inst_addr_i = addr;
    endtask

    task automatic drain(input int max_cycles);
        idle_inputs();
        for (int i = 0; i < max_cycles && model_q.size() != 0; i++) tick();
        n_checks++;
        if (model_q.size() != 0 || count_o !== '0) begin
            n_fail++;
            $display("FAIL drain: count_o %0d model %0d, both required 0", count_o, model_q.size());
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0 || inst_o !== NOP ||
            inst_addr_o !== '0 || count_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready %b valid %b inst %h addr %h count %0d, required 0 0 %h 0 0",
                     in_ready_o, out_valid_o, inst_o, inst_addr_o, count_o, NOP);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_q.delete();
        #1;
        n_checks++;
        if (in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after: got %b expected 1", in_ready_o);
        end
        tick();
        tick();
    endtask

    task automatic test_two_push();
        drive_push(32'hAAAA0001, 32'h100);
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || inst_o !== NOP) begin
            n_fail++;
            $display("FAIL no_bypass: valid %b inst %h, required 0 %h", out_valid_o, inst_o, NOP);
        end
        tick();
        n_checks++;
        if (out_valid_o !== 1'b1 || inst_addr_o !== 32'h100) begin
            n_fail++;
            $display("FAIL first_visible: valid %b addr %h, required 1 00000100", out_valid_o, inst_addr_o);
        end
        drive_push(32'hAAAA0002, 32'h104);
        tick();
        drain(6);
    endtask

    task automatic test_hold_full();
        hold_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_push(32'hBBBB0000 + k, 32'h100 + 4 * k);
            if (k == 4) begin
                #1;
                n_checks++;
                if (in_ready_o !== 1'b0 || count_o !== CNT_W'(4)) begin
                    n_fail++;
                    $display("FAIL full_ready: ready %b count %0d, required 0 4", in_ready_o, count_o);
                end
            end
            tick();
        end
        in_valid_i = 1'b0;
        hold_i     = 1'b0;
        tick();
        n_checks++;
        if (in_ready_o !== 1'b1 || inst_addr_o !== 32'h104) begin
            n_fail++;
            $display("FAIL ready_after_pop: ready %b head %h, required 1 00000104", in_ready_o, inst_addr_o);
        end
        drain(8);
    endtask

    task automatic test_flush();
        hold_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_push(32'hCCCC0000 + k, 32'h200 + 4 * k);
            tick();
        end
        jump_flag_i = 1'b1;
        drive_push(32'hDEAD0000, 32'h2F0);
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || inst_o !== NOP) begin
            n_fail++;
            $display("FAIL flush_masks: valid %b inst %h, required 0 %h", out_valid_o, inst_o, NOP);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (count_o !== '0) begin
            n_fail++;
            $display("FAIL flush_count: got %0d expected 0", count_o);
        end
        drive_push(32'hEEEE0001, 32'h300);
        tick();
        in_valid_i = 1'b0;
        hold_i     = 1'b1;
        #1;
        n_checks++;
        if (count_o !== CNT_W'(1) || inst_o !== 32'hEEEE0001) begin
            n_fail++;
            $display("FAIL after_flush: count %0d inst %h, required 1 eeee0001", count_o, inst_o);
        end
        tick();
        int_flag_i = 1'b1;
        tick();
        int_flag_i = 1'b0;
        #1;
        n_checks++;
        if (count_o !== '0) begin
            n_fail++;
            $display("FAIL int_flush_count: got %0d expected 0", count_o);
        end
        drain(4);
    endtask

    task automatic test_halt();
        halt_req_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_push(32'hF0F00000 + k, 32'h400 + 4 * k);
            tick();
        end
        halt_req_i = 1'b0;
        drive_push(32'hF0F0AAAA, 32'h500);
        #1;
        n_checks++;
        if (in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_release_ready: got %b expected 1", in_ready_o);
        end
        tick();
        drain(4);
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] prev_addr;
        hold_i = 1'b1;
        drive_push(32'h11110000, 32'h600);
        tick();
        drive_push(32'h11110001, 32'h604);
        tick();
        hold_i    = 1'b0;
        prev_addr = '0;
        for (int k = 2; k < 12; k++) begin
            drive_push(32'h11110000 + k, 32'h600 + 4 * k);
            #1;
            n_checks++;
            if (count_o !== CNT_W'(2) || !(inst_addr_o > prev_addr)) begin
                n_fail++;
                $display("FAIL b2b k=%0d: count %0d addr %h prev %h, required count 2 and increasing addr",
                         k, count_o, inst_addr_o, prev_addr);
            end
            prev_addr = inst_addr_o;
            tick();
        end
        // Assert reset between edges; outputs must clear without waiting for clk.
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== '0 ||
            count_o !== '0 || in_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid %b inst %h addr %h count %0d ready %b, required 0 %h 0 0 0",
                     out_valid_o, inst_o, inst_addr_o, count_o, in_ready_o, NOP);
        end
        model_q.delete();
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_two_push();
        test_hold_full();
        test_flush();
        test_halt();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
